// File: rtl/scanline_irq_pkg.sv
// Shared definitions for the scanline IRQ counter: register-select encodings,
// counter width and the register-write decode used by the top.
package scanline_irq_pkg;

  localparam int SIRQ_W = 8;

  typedef enum logic [1:0] {
    SIRQ_LATCH   = 2'd0,
    SIRQ_RELOAD  = 2'd1,
    SIRQ_DISABLE = 2'd2,
    SIRQ_ENABLE  = 2'd3
  } sirq_reg_e;

  // One-hot view of a register write; at most one field is set per cycle.
  typedef struct packed {
    logic latch;
    logic reload;
    logic dis;
    logic ena;
  } sirq_wr_t;

  function automatic sirq_wr_t sirq_decode(input logic we, input sirq_reg_e sel);
    sirq_wr_t wr;
    wr        = '0;
    wr.latch  = we && (sel == SIRQ_LATCH);
    wr.reload = we && (sel == SIRQ_RELOAD);
    wr.dis    = we && (sel == SIRQ_DISABLE);
    wr.ena    = we && (sel == SIRQ_ENABLE);
    return wr;
  endfunction

endpackage

// File: rtl/a12_edge_filter.sv
// PPU A12 synchronizer and low-time filter: emits a one-cycle tick on a
// synchronized rising edge that followed at least A12_LOW_MIN low samples.
module a12_edge_filter #(
  parameter int A12_LOW_MIN = 3
) (
  input  logic m2,
  input  logic reset,
  input  logic ppu_a12,
  output logic o_tick
);

  localparam logic [2:0] LOW_MIN = 3'(A12_LOW_MIN);

  logic       r_sync1;
  logic       r_a12_s;
  logic [2:0] r_low_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge m2) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_a12_s   <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_sync1 <= ppu_a12;
      r_a12_s <= r_sync1;
      if (r_a12_s)
        r_low_cnt <= '0;
      else if (r_low_cnt != LOW_MIN)
        r_low_cnt <= r_low_cnt + 3'd1;
    end
  end

  // low_cnt is only nonzero if a12_s was low last cycle, so a high a12_s with a
  // full count is by construction the first high sample of a qualified edge.
  assign o_tick = r_a12_s && (r_low_cnt == LOW_MIN);

endmodule

// File: rtl/scanline_irq_counter.sv
// MMC3-style scanline IRQ counter clocked by M2. Define SCANLINE_IRQ_ALT_EN for
// the MMC3A variant (zero latch fires only once after a reload write).
import scanline_irq_pkg::*;

module scanline_irq_counter #(
  parameter int A12_LOW_MIN = 3
) (
  input  logic              m2,
  input  logic              reset,
  input  logic              sel,
  input  logic              ppu_a12,
  input  logic              reg_we,
  input  logic [1:0]        reg_sel,
  input  logic [7:0]        reg_data,
  output logic              irq_out,
  output logic [SIRQ_W-1:0] counter_q
);

  logic              w_filter_tick;
  logic              w_tick;
  sirq_wr_t          w_wr;
  logic              w_reload_now;
  logic [SIRQ_W-1:0] w_next_cnt;
  logic              w_irq_fire;

  logic [SIRQ_W-1:0] r_counter;
  logic [SIRQ_W-1:0] r_latch;
  logic              r_reload_pending;
  logic              r_enabled;
  logic              r_irq;

  a12_edge_filter #(
    .A12_LOW_MIN (A12_LOW_MIN)
  ) u_a12_filter (
    .m2      (m2),
    .reset   (reset),
    .ppu_a12 (ppu_a12),
    .o_tick  (w_filter_tick)
  );

  assign w_tick = w_filter_tick && sel;

  // NOTE: every signal written here gets a default first, so no path through the
  // block can leave it unassigned and infer a latch.
  always_comb begin
    w_wr         = sirq_decode(reg_we, sirq_reg_e'(reg_sel));
    w_reload_now = (r_counter == '0) || r_reload_pending;
    w_next_cnt   = w_reload_now ? r_latch : (r_counter - SIRQ_W'(1));
    w_irq_fire   = 1'b0;
    // A reload write discards a coincident tick, including its IRQ.
    if (w_tick && !w_wr.reload && r_enabled && (w_next_cnt == '0)) begin
`ifdef SCANLINE_IRQ_ALT_EN
      w_irq_fire = (r_counter != '0) || r_reload_pending;
`else
      w_irq_fire = 1'b1;
`endif
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      r_counter        <= '0;
      r_latch          <= '0;
      r_reload_pending <= 1'b0;
      r_enabled        <= 1'b0;
      r_irq            <= 1'b0;
    end else begin
      if (w_wr.reload) begin
        r_counter        <= '0;
        r_reload_pending <= 1'b1;
      end else if (w_tick) begin
        r_counter <= w_next_cnt;
        if (w_reload_now)
          r_reload_pending <= 1'b0;
      end

      // A tick in the same cycle has already used the old latch via w_next_cnt.
      if (w_wr.latch)
        r_latch <= reg_data;

      if (w_wr.dis)
        r_enabled <= 1'b0;
      else if (w_wr.ena)
        r_enabled <= 1'b1;

      // Tick decisions use the pre-write r_enabled, so a coincident enable
      // write cannot raise an IRQ and a coincident disable always wins.
      if (!sel || w_wr.dis)
        r_irq <= 1'b0;
      else if (w_irq_fire)
        r_irq <= 1'b1;
    end
  end

  assign irq_out   = r_irq && sel;
  assign counter_q = r_counter;

endmodule

// File: tb/tb_scanline_irq_counter.sv
// Directed plus randomized bench for scanline_irq_counter against a reference
// model built from the scanline-counter rules; honours SCANLINE_IRQ_ALT_EN.
module tb_scanline_irq_counter;

  localparam int LOW_MIN = 3;

  logic       m2;
  logic       reset;
  logic       sel;
  logic       ppu_a12;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       irq_out;
  logic [7:0] counter_q;

  int total = 0;
  int bad   = 0;

  // Reference state.
  logic [7:0] m_cnt, m_latch;
  bit         m_pend, m_en, m_irq;
  bit         raw_q[$];
  bit         s_hist[$];

  scanline_irq_counter #(.A12_LOW_MIN(LOW_MIN)) dut (
    .m2        (m2),
    .reset     (reset),
    .sel       (sel),
    .ppu_a12   (ppu_a12),
    .reg_we    (reg_we),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .irq_out   (irq_out),
    .counter_q (counter_q)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One m2 cycle: model consumes the inputs seen at the rising edge, outputs are
  // compared on the falling edge; the caller changes inputs after that.
  task automatic step();
    bit cur_s, tick, fire, wr_l, wr_r, wr_d, wr_e;
    int zeros;
    logic [7:0] old_cnt;
    bit old_pend, old_en;
    @(posedge m2);
    if (reset) begin
      m_cnt = 8'd0; m_latch = 8'd0; m_pend = 0; m_en = 0; m_irq = 0;
      raw_q.delete();
      s_hist.delete();
      s_hist.push_back(1'b0);
    end else begin
      // Count consecutive low synchronized samples preceding the current one.
      cur_s = s_hist[$];
      zeros = 0;
      for (int i = s_hist.size() - 2; i >= 0; i--) begin
        if (s_hist[i] || zeros >= 8) break;
        zeros++;
      end
      tick = sel && cur_s && (zeros >= LOW_MIN);
      wr_l = reg_we && (reg_sel == 2'd0);
      wr_r = reg_we && (reg_sel == 2'd1);
      wr_d = reg_we && (reg_sel == 2'd2);
      wr_e = reg_we && (reg_sel == 2'd3);
      old_cnt = m_cnt; old_pend = m_pend; old_en = m_en;
      fire = 0;
      if (wr_r) begin
        m_cnt = 8'd0; m_pend = 1;
      end else if (tick) begin
        if (old_cnt == 8'd0 || old_pend) begin
          m_cnt = m_latch; m_pend = 0;
        end else begin
          m_cnt = old_cnt - 8'd1;
        end
`ifdef SCANLINE_IRQ_ALT_EN
        fire = (m_cnt == 8'd0) && old_en && (old_cnt != 8'd0 || old_pend);
`else
        fire = (m_cnt == 8'd0) && old_en;
`endif
      end
      if (wr_l) m_latch = reg_data;
      if (wr_d) m_en = 0;
      else if (wr_e) m_en = 1;
      if (!sel || wr_d) m_irq = 0;
      else if (fire) m_irq = 1;
      // Synchronized A12 is the raw sample from two edges back (zero after reset).
      raw_q.push_back(ppu_a12);
      s_hist.push_back(raw_q.size() >= 2 ? raw_q[raw_q.size() - 2] : 1'b0);
      if (s_hist.size() > 16) void'(s_hist.pop_front());
      if (raw_q.size() > 4) void'(raw_q.pop_front());
    end
    @(negedge m2);
    check("model_cnt", counter_q, m_cnt);
    check("model_irq", 8'(irq_out), 8'(m_irq && sel));
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    reg_we = 1'b1; reg_sel = s; reg_data = d;
    step();
    reg_we = 1'b0;
  endtask

  task automatic pulse(input int low_n, input int high_n);
    ppu_a12 = 1'b0;
    repeat (low_n) step();
    ppu_a12 = 1'b1;
    repeat (high_n) step();
  endtask

  logic exp_irq;
  int   run_left;

  initial begin
    reset = 1'b1; sel = 1'b1; ppu_a12 = 1'b0;
    reg_we = 1'b0; reg_sel = 2'd0; reg_data = 8'd0;
    repeat (2) step();
    check("reset_cnt", counter_q, 8'd0);
    check("reset_irq", 8'(irq_out), 8'd0);
    reset = 1'b0;

    // Counting 3,2,1,0 and IRQ three edges after the fourth raw rise.
    wr(2'd0, 8'd3);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    for (int p = 0; p < 3; p++) begin
      pulse(4, 3);
      check("count_seq", counter_q, 8'(3 - p));
    end
    ppu_a12 = 1'b0;
    repeat (4) step();
    ppu_a12 = 1'b1;
    step(); check("irq_edge1", 8'(irq_out), 8'd0);
    step(); check("irq_edge2", 8'(irq_out), 8'd0);
    step(); check("irq_edge3", 8'(irq_out), 8'd1);
    check("count_zero", counter_q, 8'd0);

    // Short low phases are rejected.
    wr(2'd2, 8'd0);
    check("ack_irq", 8'(irq_out), 8'd0);
    repeat (6) pulse(1, 1);
    check("short_cnt", counter_q, 8'd0);
    check("short_irq", 8'(irq_out), 8'd0);

    // Zero latch: fires every tick by default, once only in the alternate mode.
    wr(2'd0, 8'd0);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(4, 3);
`ifdef SCANLINE_IRQ_ALT_EN
      exp_irq = (i == 0);
`else
      exp_irq = 1'b1;
`endif
      check("zero_latch_irq", 8'(irq_out), 8'(exp_irq));
      wr(2'd2, 8'd0);
      wr(2'd3, 8'd0);
    end

    // Reload write coinciding with a tick at counter 5.
    wr(2'd2, 8'd0);
    wr(2'd0, 8'd6);
    wr(2'd1, 8'd0);
    pulse(4, 3);
    pulse(4, 3);
    check("pre_reload_cnt", counter_q, 8'd5);
    ppu_a12 = 1'b0;
    repeat (4) step();
    ppu_a12 = 1'b1;
    step();
    step();
    reg_we = 1'b1; reg_sel = 2'd1;
    step();
    reg_we = 1'b0;
    check("reload_wins", counter_q, 8'd0);
    pulse(4, 3);
    check("reload_latch", counter_q, 8'd6);

    // Pending IRQ survives an enable write and is cleared by a disable write.
    wr(2'd0, 8'd1);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    pulse(4, 3);
    pulse(4, 3);
    check("pend_irq", 8'(irq_out), 8'd1);
    wr(2'd3, 8'd0);
    check("enable_keeps", 8'(irq_out), 8'd1);
    wr(2'd2, 8'd0);
    check("disable_clears", 8'(irq_out), 8'd0);

    // sel low freezes counting; reset mid-count clears everything.
    wr(2'd0, 8'd4);
    wr(2'd1, 8'd0);
    wr(2'd3, 8'd0);
    pulse(4, 3);
    check("sel_pre_cnt", counter_q, 8'd4);
    sel = 1'b0;
    repeat (3) pulse(4, 3);
    check("sel_off_cnt", counter_q, 8'd4);
    check("sel_off_irq", 8'(irq_out), 8'd0);
    sel = 1'b1;
    pulse(4, 3);
    check("sel_on_cnt", counter_q, 8'd3);
    reset = 1'b1; reg_we = 1'b1; reg_sel = 2'd0; reg_data = 8'h99;
    step();
    reset = 1'b0; reg_we = 1'b0;
    check("midreset_cnt", counter_q, 8'd0);
    check("midreset_irq", 8'(irq_out), 8'd0);

    // Randomized traffic checked cycle by cycle against the model.
    run_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (run_left == 0) begin
        ppu_a12  = ~ppu_a12;
        run_left = ppu_a12 ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 6));
      end
      run_left--;
      reg_we   = ($urandom_range(0, 7) == 0);
      reg_sel  = 2'($urandom_range(0, 3));
      reg_data = 8'($urandom_range(0, 3));
      sel      = ($urandom_range(0, 24) != 0);
      reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; reg_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
